// File: rtl/gigatron_pkg.sv
// ---------------------------------------------------------------------------
// gigatron_pkg
// Shared definitions for the Gigatron RAM arbiter:
//   - default RAM geometry (32K x 8)
//   - owner-state encoding, also used as the winner code of the pick logic
// No ports (package).
// ---------------------------------------------------------------------------
package gigatron_pkg;

  localparam int RAM_ADDR_WIDTH = 15;
  localparam int RAM_DATA_WIDTH = 8;

  // OWN_IDLE doubles as "no winner" when the pick logic sees no request.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/gigatron_arb_pick.sv
// ---------------------------------------------------------------------------
// gigatron_arb_pick
// Combinational winner selector for the shared RAM port.
// Video wins by default; the CPU wins a contended cycle only when the
// video run counter has reached its limit.
// Ports:
//   i_Cpu_Req   CPU request (already gated by reset in the parent)
//   i_Vid_Req   video request (already gated by reset in the parent)
//   i_At_Limit  run counter equals the maximum video run
//   o_Winner    OWN_VID / OWN_CPU, or OWN_IDLE when nobody requests
// ---------------------------------------------------------------------------
module gigatron_arb_pick
  import gigatron_pkg::*;
(
  input  logic   i_Cpu_Req,
  input  logic   i_Vid_Req,
  input  logic   i_At_Limit,
  output owner_t o_Winner
);

  always_comb begin
    o_Winner = OWN_IDLE;
    if (i_Vid_Req && (!i_Cpu_Req || !i_At_Limit)) begin
      o_Winner = OWN_VID;
    end else if (i_Cpu_Req) begin
      o_Winner = OWN_CPU;
    end
  end

endmodule

// File: rtl/gigatron_ram_arbiter.sv
// ---------------------------------------------------------------------------
// gigatron_ram_arbiter
// Shares one single-port synchronous RAM between the Gigatron CPU and the
// VGA scanout fetcher. Video has priority; after MAX_VIDEO_RUN consecutive
// video grants against a pending CPU request the CPU gets one cycle.
//
// Ports:
//   i_Clk, i_Reset                  clock, synchronous active-high reset
//   i_Cpu_Req/We/Addr/WData         CPU request (held until o_Cpu_Gnt)
//   o_Cpu_Gnt                       combinational grant
//   o_Cpu_Valid/o_Cpu_RData         read data, 2 cycles after grant
//   i_Vid_Req/i_Vid_Addr            video read request (held until o_Vid_Gnt)
//   o_Vid_Gnt                       combinational grant
//   o_Vid_Valid/o_Vid_RData         read data, 2 cycles after grant
//   o_Ram_Addr/WData/We             registered RAM command
//   i_Ram_RData                     RAM data, valid the cycle after the
//                                   address register is loaded
// Optional (macro ARB_STATS_EN):
//   o_Cpu_Stall_Count               saturating count of CPU stall cycles
//   o_Max_Wait                      longest consecutive CPU stall seen
// ---------------------------------------------------------------------------
module gigatron_ram_arbiter
  import gigatron_pkg::*;
#(
  parameter int ADDR_WIDTH    = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = RAM_DATA_WIDTH,
  parameter int MAX_VIDEO_RUN = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Cpu_Req,
  input  logic                  i_Cpu_We,
  input  logic [ADDR_WIDTH-1:0] i_Cpu_Addr,
  input  logic [DATA_WIDTH-1:0] i_Cpu_WData,
  output logic                  o_Cpu_Gnt,
  output logic                  o_Cpu_Valid,
  output logic [DATA_WIDTH-1:0] o_Cpu_RData,
  input  logic                  i_Vid_Req,
  input  logic [ADDR_WIDTH-1:0] i_Vid_Addr,
  output logic                  o_Vid_Gnt,
  output logic                  o_Vid_Valid,
  output logic [DATA_WIDTH-1:0] o_Vid_RData,
  output logic [ADDR_WIDTH-1:0] o_Ram_Addr,
  output logic [DATA_WIDTH-1:0] o_Ram_WData,
  output logic                  o_Ram_We,
  input  logic [DATA_WIDTH-1:0] i_Ram_RData
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           o_Cpu_Stall_Count,
  output logic [3:0]            o_Max_Wait
`endif
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_VIDEO_RUN);

  // Owner FSM and run counter
  owner_t     r_state;
  owner_t     w_state_next;
  logic [3:0] r_run_cnt;
  logic [3:0] w_run_next;

  // Winner selection
  logic   w_cpu_req;
  logic   w_vid_req;
  logic   w_at_limit;
  owner_t w_winner;
  logic   w_cpu_win;
  logic   w_vid_win;

  // Pipeline
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_ram_we;
  logic                  r_cpu_rd_p1;
  logic                  r_vid_rd_p1;
  logic                  r_cpu_valid;
  logic                  r_vid_valid;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_vid_rdata;

  // Requests seen during reset are masked so nothing is granted until the
  // first cycle after release.
  assign w_cpu_req  = i_Cpu_Req & ~i_Reset;
  assign w_vid_req  = i_Vid_Req & ~i_Reset;
  assign w_at_limit = (r_run_cnt == RUN_MAX);

  gigatron_arb_pick u_pick (
    .i_Cpu_Req  (w_cpu_req),
    .i_Vid_Req  (w_vid_req),
    .i_At_Limit (w_at_limit),
    .o_Winner   (w_winner)
  );

  assign w_cpu_win = (w_winner == OWN_CPU);
  assign w_vid_win = (w_winner == OWN_VID);
  assign o_Cpu_Gnt = w_cpu_win;
  assign o_Vid_Gnt = w_vid_win;

  // ---------------------------------------------------------------------
  // Owner FSM: records the last winner; IDLE on any cycle without requests.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = w_winner;
    w_run_next   = r_run_cnt;
    if (!w_cpu_req || w_cpu_win) begin
      w_run_next = '0;
    end else if (w_vid_win) begin
      // Coming from IDLE or CPU ownership the run always restarts at one.
      if (r_state != OWN_VID) begin
        w_run_next = 4'd1;
      end else if (r_run_cnt != RUN_MAX) begin
        w_run_next = r_run_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state   <= OWN_IDLE;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_next;
    end
  end

  // ---------------------------------------------------------------------
  // Issue stage (address register) and return stage (data + valid).
  // Reset flushes both stages so in-flight reads never report valid.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_cpu_rd_p1 <= 1'b0;
      r_vid_rd_p1 <= 1'b0;
      r_cpu_valid <= 1'b0;
      r_vid_valid <= 1'b0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
    end else begin
      r_ram_we    <= w_cpu_win & i_Cpu_We;
      r_cpu_rd_p1 <= w_cpu_win & ~i_Cpu_We;
      r_vid_rd_p1 <= w_vid_win;
      if (w_cpu_win) begin
        r_ram_addr  <= i_Cpu_Addr;
        r_ram_wdata <= i_Cpu_WData;
      end else if (w_vid_win) begin
        r_ram_addr  <= i_Vid_Addr;
      end
      r_cpu_valid <= r_cpu_rd_p1;
      r_vid_valid <= r_vid_rd_p1;
      if (r_cpu_rd_p1) begin
        r_cpu_rdata <= i_Ram_RData;
      end
      if (r_vid_rd_p1) begin
        r_vid_rdata <= i_Ram_RData;
      end
    end
  end

  assign o_Ram_Addr  = r_ram_addr;
  assign o_Ram_WData = r_ram_wdata;
  assign o_Ram_We    = r_ram_we;
  assign o_Cpu_Valid = r_cpu_valid;
  assign o_Cpu_RData = r_cpu_rdata;
  assign o_Vid_Valid = r_vid_valid;
  assign o_Vid_RData = r_vid_rdata;

`ifdef ARB_STATS_EN
  // ---------------------------------------------------------------------
  // Debug statistics for the LED / 7-segment display.
  // ---------------------------------------------------------------------
  logic [15:0] r_stall_cnt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  r_max_wait;
  logic [3:0]  w_wait_inc;
  logic        w_cpu_stall;

  assign w_cpu_stall = w_cpu_req & ~w_cpu_win;
  assign w_wait_inc  = r_wait_cnt + 4'd1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
      r_max_wait  <= '0;
    end else if (w_cpu_stall) begin
      if (r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (r_wait_cnt != 4'hF) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc > r_max_wait) begin
          r_max_wait <= w_wait_inc;
        end
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign o_Cpu_Stall_Count = r_stall_cnt;
  assign o_Max_Wait        = r_max_wait;
`endif

endmodule
